// File: rtl/sha256_nonce_scanner.sv
// Nonce scanner wrapped around a pipelined single-block SHA-256 core.
// Feeds one candidate block per cycle (template with message word 2 replaced
// by the nonce), tracks each nonce through the fixed hash latency and holds
// digests with enough leading zero bits in a valid/ready result register.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i, abort_i       scan request (IDLE only) / scan abort (ISSUE, DRAIN)
//   msg_template_i         padded 512-bit block, word 0 in [511:480]
//   nonce_start_i/end_i    inclusive nonce range, may wrap through 0
//   core_input_o           candidate block to the hash core
//   core_hash_i            digest from the hash core, H0 in [255:224]
//   busy_o, done_o         scan in progress / one-cycle completion pulse
//   found_valid_o/ready_i  result handshake
//   found_nonce_o/hash_o   held hit
//   drop_cnt_o             saturating count of hits lost to a full register
module sha256_nonce_scanner #(
  parameter int unsigned HASH_LATENCY = 64,
  parameter int unsigned ZERO_BITS    = 16,
  parameter int unsigned DROP_W       = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [511:0]      msg_template_i,
  input  logic [31:0]       nonce_start_i,
  input  logic [31:0]       nonce_end_i,
  output logic [511:0]      core_input_o,
  input  logic [255:0]      core_hash_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              found_valid_o,
  input  logic              found_ready_i,
  output logic [31:0]       found_nonce_o,
  output logic [255:0]      found_hash_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int unsigned CntW = $clog2(HASH_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_e;

  state_e            state_q, state_d;
  logic [511:0]      tmpl_q, tmpl_d;
  logic [31:0]       cur_q, cur_d;
  logic [31:0]       end_q, end_d;
  logic [511:0]      core_input_q, core_input_d;
  logic              issue_vld_q, issue_vld_d;
  logic [CntW-1:0]   drain_q, drain_d;
  logic              clear_dl;

  logic              found_valid_q, found_valid_d;
  logic [31:0]       found_nonce_q, found_nonce_d;
  logic [255:0]      found_hash_q, found_hash_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  // issue_vld_q tags the nonce currently on core_input_q; the delay line
  // proper starts one stage later, so its last entry lines up with core_hash_i.
  logic [HASH_LATENCY-1:0] dl_vld_q;
  logic [31:0]             dl_nonce_q [HASH_LATENCY];

  logic tap_vld, zero_ok, hit;
  logic unused_tmpl;

  assign unused_tmpl = ^tmpl_q[447:416];

  // Scan control
  always_comb begin
    state_d      = state_q;
    tmpl_d       = tmpl_q;
    cur_d        = cur_q;
    end_d        = end_q;
    core_input_d = core_input_q;
    issue_vld_d  = 1'b0;
    drain_d      = drain_q;
    clear_dl     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          tmpl_d  = msg_template_i;
          cur_d   = nonce_start_i;
          end_d   = nonce_end_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (abort_i) begin
          clear_dl = 1'b1;
          state_d  = StIdle;
        end else begin
          core_input_d = {tmpl_q[511:448], cur_q, tmpl_q[415:0]};
          issue_vld_d  = 1'b1;
          cur_d        = cur_q + 32'd1;
          if (cur_q == end_q) begin
            drain_d = CntW'(HASH_LATENCY);
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (abort_i) begin
          clear_dl = 1'b1;
          state_d  = StIdle;
        end else if (drain_q == '0) begin
          state_d = StFin;
        end else begin
          drain_d = drain_q - CntW'(1);
        end
      end
      StFin: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      tmpl_q       <= '0;
      cur_q        <= '0;
      end_q        <= '0;
      core_input_q <= '0;
      issue_vld_q  <= 1'b0;
      drain_q      <= '0;
    end else begin
      state_q      <= state_d;
      tmpl_q       <= tmpl_d;
      cur_q        <= cur_d;
      end_q        <= end_d;
      core_input_q <= core_input_d;
      issue_vld_q  <= issue_vld_d;
      drain_q      <= drain_d;
    end
  end

  // Nonce/valid delay line
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dl_vld_q <= '0;
      for (int i = 0; i < int'(HASH_LATENCY); i++) dl_nonce_q[i] <= '0;
    end else begin
      dl_vld_q[0]   <= issue_vld_q & ~clear_dl;
      dl_nonce_q[0] <= core_input_q[447:416];
      for (int i = 1; i < int'(HASH_LATENCY); i++) begin
        dl_vld_q[i]   <= dl_vld_q[i-1] & ~clear_dl;
        dl_nonce_q[i] <= dl_nonce_q[i-1];
      end
    end
  end

  assign tap_vld = dl_vld_q[HASH_LATENCY-1];

  if (ZERO_BITS == 0) begin : g_any
    assign zero_ok = 1'b1;
  end else begin : g_zero
    assign zero_ok = (core_hash_i[255 -: ZERO_BITS] == '0);
  end

  assign hit = tap_vld & zero_ok;

  // Result register; a hit in a handshake cycle replaces the accepted one.
  always_comb begin
    found_valid_d = found_valid_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    drop_cnt_d    = drop_cnt_q;
    if (hit) begin
      if (!found_valid_q || found_ready_i) begin
        found_valid_d = 1'b1;
        found_nonce_d = dl_nonce_q[HASH_LATENCY-1];
        found_hash_d  = core_hash_i;
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end else if (found_valid_q && found_ready_i) begin
      found_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      found_valid_q <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      drop_cnt_q    <= '0;
    end else begin
      found_valid_q <= found_valid_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign core_input_o  = core_input_q;
  assign busy_o        = (state_q == StIssue) || (state_q == StDrain);
  assign done_o        = (state_q == StFin);
  assign found_valid_o = found_valid_q;
  assign found_nonce_o = found_nonce_q;
  assign found_hash_o  = found_hash_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_sha256_nonce_scanner.sv
// Directed bench for sha256_nonce_scanner with a behavioural SHA-256 core
// (fixed-latency pipeline) per DUT instance. dut_a: every nonce hits, 3-bit
// drop counter; dut_b: one leading zero bit required.
module tb_sha256_nonce_scanner;

  localparam int unsigned L = 16;
  localparam logic [255:0] AbcHash =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] Iv [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start_a, start_b, abort_a, ready;
  logic [511:0] tmpl;
  logic [31:0]  n_start, n_end;

  logic [511:0] core_input_a, core_input_b;
  logic [255:0] core_hash_a, core_hash_b, found_hash_a, found_hash_b;
  logic         busy_a, done_a, fv_a, busy_b, done_b, fv_b;
  logic [31:0]  fn_a, fn_b;
  logic [2:0]   drop_a;
  logic [7:0]   drop_b;

  int checks = 0;
  int errors = 0;
  int done_cnt_a = 0;

  sha256_nonce_scanner #(.HASH_LATENCY(L), .ZERO_BITS(0), .DROP_W(3)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .abort_i(abort_a),
    .msg_template_i(tmpl), .nonce_start_i(n_start), .nonce_end_i(n_end),
    .core_input_o(core_input_a), .core_hash_i(core_hash_a), .busy_o(busy_a),
    .done_o(done_a), .found_valid_o(fv_a), .found_ready_i(ready),
    .found_nonce_o(fn_a), .found_hash_o(found_hash_a), .drop_cnt_o(drop_a)
  );

  sha256_nonce_scanner #(.HASH_LATENCY(L), .ZERO_BITS(1), .DROP_W(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .abort_i(1'b0),
    .msg_template_i(tmpl), .nonce_start_i(n_start), .nonce_end_i(n_end),
    .core_input_o(core_input_b), .core_hash_i(core_hash_b), .busy_o(busy_b),
    .done_o(done_b), .found_valid_o(fv_b), .found_ready_i(ready),
    .found_nonce_o(fn_b), .found_hash_o(found_hash_b), .drop_cnt_o(drop_b)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_blk(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    a = Iv[0]; b = Iv[1]; c = Iv[2]; d = Iv[3];
    e = Iv[4]; f = Iv[5]; g = Iv[6]; h = Iv[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + Iv[0], b + Iv[1], c + Iv[2], d + Iv[3],
            e + Iv[4], f + Iv[5], g + Iv[6], h + Iv[7]};
  endfunction

  function automatic logic [511:0] cand(input logic [31:0] n);
    logic [511:0] r;
    r = tmpl;
    r[447:416] = n;
    return r;
  endfunction

  // Behavioural hash cores: digest of core_input at cycle t appears at t+L.
  logic [255:0] hp_a [L];
  logic [255:0] hp_b [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) begin
      hp_a[i] <= hp_a[i-1];
      hp_b[i] <= hp_b[i-1];
    end
    hp_a[0] <= sha256_blk(core_input_a);
    hp_b[0] <= sha256_blk(core_input_b);
  end
  assign core_hash_a = hp_a[L-1];
  assign core_hash_b = hp_b[L-1];

  always @(posedge clk) if (done_a) done_cnt_a <= done_cnt_a + 1;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the caller at the negedge of the first ISSUE cycle.
  task automatic kick_a(input logic [31:0] s, input logic [31:0] e);
    @(negedge clk);
    n_start = s; n_end = e; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!done_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_a_seen", 512'(done_a), 512'(1));
  endtask

  task automatic check_zero_a(input string pfx);
    check_eq({pfx, "_core_input"}, core_input_a, '0);
    check_eq({pfx, "_busy"}, 512'(busy_a), '0);
    check_eq({pfx, "_done"}, 512'(done_a), '0);
    check_eq({pfx, "_found_valid"}, 512'(fv_a), '0);
    check_eq({pfx, "_found_nonce"}, 512'(fn_a), '0);
    check_eq({pfx, "_found_hash"}, 512'(found_hash_a), '0);
    check_eq({pfx, "_drop_cnt"}, 512'(drop_a), '0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc0, cyc, busy_cyc;
    bit fv_seen, busy_seen;
    logic [31:0] n;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; ready = 1'b1;
    n_start = '0; n_end = '0;
    tmpl = '0;
    tmpl[511:480] = 32'h61626380;
    tmpl[31:0]    = 32'h00000018;
    repeat (2) @(negedge clk);
    check_zero_a("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic scan 0..3, every nonce hits.
    dc0 = done_cnt_a;
    kick_a(32'd0, 32'd3);
    check_eq("basic_busy", 512'(busy_a), 512'(1));
    @(negedge clk);
    check_eq("basic_core_input0", core_input_a, cand(32'd0));
    repeat (L + 1) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_eq("basic_fv", 512'(fv_a), 512'(1));
      check_eq("basic_nonce", 512'(fn_a), 512'(k));
      check_eq("basic_hash", 512'(found_hash_a),
               512'((k == 0) ? AbcHash : sha256_blk(cand(32'(k)))));
      check_eq("basic_done", 512'(done_a), 512'(k == 3));
      @(negedge clk);
    end
    check_eq("basic_fv_clear", 512'(fv_a), '0);
    check_eq("basic_idle", 512'(busy_a), '0);
    check_eq("basic_done_once", 512'(done_cnt_a - dc0), 512'(1));
    check_eq("basic_drop", 512'(drop_a), '0);

    // No hit: "abc" digest starts 0xba, one zero bit required.
    @(negedge clk);
    n_start = 32'd0; n_end = 32'd0; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0; busy_cyc = 0; fv_seen = 1'b0;
    while (!done_b && cyc < 200) begin
      if (busy_b) busy_cyc++;
      if (fv_b) fv_seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check_eq("nohit_done_seen", 512'(done_b), 512'(1));
    check_eq("nohit_done_time", 512'(cyc), 512'(L + 2));
    check_eq("nohit_busy_span", 512'(busy_cyc), 512'(L + 2));
    check_eq("nohit_busy_fin", 512'(busy_b), '0);
    check_eq("nohit_no_found", 512'(fv_seen | fv_b), '0);

    // Backpressure 10..14 with ready low: first hit held, four dropped.
    ready = 1'b0;
    kick_a(32'd10, 32'd14);
    wait_done_a();
    check_eq("bp_fv", 512'(fv_a), 512'(1));
    check_eq("bp_nonce", 512'(fn_a), 512'(10));
    check_eq("bp_hash", 512'(found_hash_a), 512'(sha256_blk(cand(32'd10))));
    check_eq("bp_drop", 512'(drop_a), 512'(4));
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check_eq("bp_release", 512'(fv_a), '0);

    // Same again: drop counter saturates at 7.
    kick_a(32'd10, 32'd14);
    wait_done_a();
    check_eq("sat_nonce", 512'(fn_a), 512'(10));
    check_eq("sat_drop", 512'(drop_a), 512'(7));
    ready = 1'b1;
    @(negedge clk);
    check_eq("sat_release", 512'(fv_a), '0);

    // Wrap FFFFFFFE..1: exactly four issues in order.
    dc0 = done_cnt_a;
    kick_a(32'hFFFF_FFFE, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n = 32'hFFFF_FFFE + 32'(k);
      check_eq("wrap_issue", core_input_a, cand(n));
    end
    repeat (L - 2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n = 32'hFFFF_FFFE + 32'(k);
      check_eq("wrap_fv", 512'(fv_a), 512'(1));
      check_eq("wrap_nonce", 512'(fn_a), 512'(n));
      @(negedge clk);
    end
    check_eq("wrap_count", 512'(fv_a), '0);
    check_eq("wrap_done_once", 512'(done_cnt_a - dc0), 512'(1));

    // Abort at issue 5 of 0..99, then restart.
    dc0 = done_cnt_a;
    kick_a(32'd0, 32'd99);
    repeat (5) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check_eq("abort_idle", 512'(busy_a), '0);
    fv_seen = 1'b0; busy_seen = 1'b0;
    for (int k = 0; k < int'(L) + 10; k++) begin
      if (fv_a) fv_seen = 1'b1;
      if (busy_a) busy_seen = 1'b1;
      @(negedge clk);
    end
    check_eq("abort_no_found", 512'(fv_seen), '0);
    check_eq("abort_stay_idle", 512'(busy_seen), '0);
    check_eq("abort_no_done", 512'(done_cnt_a - dc0), '0);
    kick_a(32'd0, 32'd0);
    check_eq("abort_restart_busy", 512'(busy_a), 512'(1));
    repeat (L + 2) @(negedge clk);
    check_eq("abort_restart_fv", 512'(fv_a), 512'(1));
    check_eq("abort_restart_hash", 512'(found_hash_a), 512'(AbcHash));

    // Asynchronous reset mid-DRAIN with a held hit.
    ready = 1'b0;
    repeat (2) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    kick_a(32'd0, 32'd3);
    cyc = 0;
    while (!fv_a && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_pre_fv", 512'(fv_a), 512'(1));
    check_eq("rst_pre_busy", 512'(busy_a), 512'(1));
    #2 rst_n = 1'b0;
    #1 check_zero_a("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    fv_seen = 1'b0; busy_seen = 1'b0;
    for (int k = 0; k < int'(L) + 8; k++) begin
      @(negedge clk);
      if (fv_a) fv_seen = 1'b1;
      if (busy_a) busy_seen = 1'b1;
    end
    check_eq("rst_no_late_hit", 512'(fv_seen), '0);
    check_eq("rst_stay_idle", 512'(busy_seen), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_nonce_scanner.md
Name: sha256_nonce_scanner

Overview:
- Upstream work feeder and downstream result checker for the pipelined single-block SHA-256 wrapper.
- Drives the wrapper's 512-bit `rx_input` with one candidate per cycle. The candidate is a message template with a 32-bit nonce substituted.
- Tracks each nonce through the fixed hash latency and tests the returned 256-bit digest for a leading-zero target.
- Presents hits to the host through a valid/ready holding register.

Parameters:
- HASH_LATENCY, 64: cycles from `core_input` change to the matching `core_hash` on the wrapper output; must be ≥1.
- ZERO_BITS, 16: number of leading digest bits that must be zero for a hit; range 0–255; 0 means every nonce hits.
- DROP_W, 8: width of the saturating dropped-hit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous assert, active-low; clears all state
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  stops the scan; honoured in ISSUE and DRAIN
- msg_template  in  512  padded message block, word 0 in [511:480]; sampled on accepted start
- nonce_start  in  32  first nonce; sampled on accepted start
- nonce_end  in  32  last nonce, inclusive; sampled on accepted start
- core_input  out  512  to wrapper `rx_input`
- core_hash  in  256  from wrapper `tx_hash`; digest word H0 in [255:224]
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse at normal scan completion
- found_valid  out  1  hit held in result register
- found_ready  in  1  host accepts the hit
- found_nonce  out  32  nonce of the held hit
- found_hash  out  256  digest of the held hit
- drop_cnt  out  DROP_W  hits lost while the register was full; saturates

Behaviour:
- Reset values: core_input=0, busy=0, done=0, found_valid=0, found_nonce=0, found_hash=0, drop_cnt=0, state=IDLE. The valid/nonce delay line is cleared.
- Candidate format: core_input = msg_template with bits [447:416] (message word 2) replaced by the current nonce. core_input is a register.
- FSM states are IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - start=1 latches the template and the range, loads cur=nonce_start, and moves to ISSUE.
  - start outside IDLE is ignored.
- ISSUE:
  - Each cycle: core_input←candidate(cur), push (valid=1, cur) into the delay line, cur←cur+1 mod 2^32.
  - The cycle that issues cur==nonce_end moves to DRAIN.
  - Wrap case: if nonce_end<nonce_start, the scan wraps through FFFFFFFF→0. The count is ((end−start) mod 2^32)+1.
  - start==end issues exactly one nonce.
- DRAIN:
  - Pushes valid=0 each cycle.
  - Stays until the last issued nonce emerges from the delay line, i.e. HASH_LATENCY cycles after its issue. Then moves to FIN.
- FIN: done=1 for one cycle, then IDLE. busy=0 in FIN.
- Abort:
  - In ISSUE or DRAIN, clears all delay-line valid bits the next cycle and goes directly to IDLE.
  - No done pulse. The held result and drop_cnt are preserved.
- Delay line: depth HASH_LATENCY, with entries {valid, nonce}.
  - The tap is aligned so that a nonce presented on core_input at cycle t is compared against core_hash at cycle t+HASH_LATENCY.
- Hit condition: tap valid and core_hash[255 -: ZERO_BITS]==0. ZERO_BITS=0 means every valid tap is a hit.
- Result register:
  - A hit loads found_nonce/found_hash with found_valid=1 on the next edge. Result latency is HASH_LATENCY+1 cycles from issue.
  - found_valid stays high until a cycle with found_valid && found_ready.
  - If a hit arrives while found_valid=1 and found_ready=0, the hit is discarded and drop_cnt increments, saturating at 2^DROP_W−1.
  - If a hit arrives in the same cycle as an accepting handshake, the new hit loads and found_valid stays 1.
  - found_* outputs are stable while found_valid=1 and found_ready=0.
- No backpressure into issue: the core pipeline cannot stall.
- drop_cnt clears only on reset.
- Asynchronous reset mid-scan returns everything to reset values immediately. Any in-flight hashes are ignored.

Test Plan:
- Bench uses a behavioural SHA-256 model with a HASH_LATENCY-cycle delay.
- Basic scan:
  - Stimulus: ZERO_BITS=0, template = "abc" padded (word0=61626380, word15=00000018), range 0..3, found_ready=1.
  - Required: found_nonce 0,1,2,3 on consecutive cycles starting at issue+HASH_LATENCY+1. Hash for nonce 0 = ba7816bf…f20015ad. done pulses once. drop_cnt=0.
- No hit:
  - Stimulus: ZERO_BITS=1, "abc" template, range 0..0.
  - Required: digest begins 0xba, so no hit. done pulses HASH_LATENCY+1 cycles after issue. busy spans exactly that interval.
- Backpressure:
  - Stimulus: ZERO_BITS=0, range 10..14, found_ready=0 throughout.
  - Required: found_nonce=10 is held, drop_cnt=4. Then found_ready=1 for one cycle drops found_valid.
- Wrap:
  - Stimulus: range FFFFFFFE..00000001.
  - Required: exactly 4 issues, in order FFFFFFFE, FFFFFFFF, 0, 1.
- Abort:
  - Stimulus: range 0..99, abort at issue 5.
  - Required: no further found_valid from in-flight nonces, no done, back in IDLE, start accepted again.
- Reset:
  - Stimulus: rst low mid-DRAIN with found_valid=1.
  - Required: all outputs return to 0 asynchronously. No hit appears after release.
